// File: rtl/fp_normalize_seq_pkg.sv
// Shared types and helpers for the fp_normalize_seq post-add normaliser.
// Optional build macro used by the top: NORM_FAST_EN (single-cycle full shift).
package fp_norm_pkg;

    // Normaliser control states
    typedef enum logic [1:0] {
        IDLE,
        ADJ,
        SHIFT,
        DONE
    } state_e;

    // Bit positions inside flags_out = {overflow, denorm, zero}
    localparam int FLG_ZERO   = 0;
    localparam int FLG_DENORM = 1;
    localparam int FLG_OVF    = 2;

    // Ceiling log2 for sizing counters; never returns less than 1 bit
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/fp_normalize_seq_if.sv
// Operand/result handshake bundle for fp_normalize_seq.
// slave = normaliser side, master = producer/consumer side.
interface fp_normalize_seq_if #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 24
);
    logic              in_valid;
    logic              in_ready;
    logic [EXP_W-1:0]  exp_in;
    logic [MANT_W-1:0] mant_in;
    logic              cout_in;
    logic              out_valid;
    logic              out_ready;
    logic [EXP_W-1:0]  exp_out;
    logic [MANT_W-1:0] mant_out;
    logic              guard_out;
    logic [2:0]        flags_out;

    modport slave (
        input  in_valid, exp_in, mant_in, cout_in, out_ready,
        output in_ready, out_valid, exp_out, mant_out, guard_out, flags_out
    );

    modport master (
        output in_valid, exp_in, mant_in, cout_in, out_ready,
        input  in_ready, out_valid, exp_out, mant_out, guard_out, flags_out
    );
endinterface

// File: rtl/fp_normalize_seq_lzc.sv
// Combinational leading-zero counter; an all-zero vector counts as W.
module norm_lzc
    import fp_norm_pkg::*;
#(
    parameter int W = 24
) (
    input  logic [W-1:0]            i_vec,
    output logic [clog2(W+1)-1:0]   o_count
);

    localparam int CW = clog2(W + 1);

    // Scan from LSB upward so the highest set bit is the last one to win
    always_comb begin
        // NOTE: o_count gets a default before the loop so no path leaves it unassigned (no latch).
        o_count = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (i_vec[i]) o_count = CW'(W - 1 - i);
        end
    end

endmodule

// File: rtl/fp_normalize_seq.sv
// Sequential post-add normaliser: carry adjust, then left shift until the
// mantissa MSB is set or the exponent reaches zero, with valid/ready on both sides.
// Build macro NORM_FAST_EN: do the whole left shift in a single SHIFT cycle.
module fp_normalize_seq
    import fp_norm_pkg::*;
#(
    parameter int EXP_W      = 8,
    parameter int MANT_W     = 24,
    parameter int SHIFT_STEP = 1
) (
    input  logic               clk,
    input  logic               rst,
    fp_normalize_seq_if.slave  bus
);

    localparam int LZC_W = clog2(MANT_W + 1);
    localparam int K_W   = (EXP_W > LZC_W) ? EXP_W : LZC_W;
    localparam logic [EXP_W-1:0] EXP_MAX = '1;

`ifdef NORM_FAST_EN
    // Cap equal to the mantissa width never limits the shift
    localparam int STEP_CAP = MANT_W;
`else
    localparam int STEP_CAP = SHIFT_STEP;
`endif

    state_e            r_state, w_state_nxt;
    logic [EXP_W-1:0]  r_exp, w_exp_nxt;
    logic [MANT_W-1:0] r_mant, w_mant_nxt;
    logic              r_cout, w_cout_nxt;
    logic              r_guard, w_guard_nxt;
    logic [2:0]        r_flags, w_flags_nxt;

    logic [LZC_W-1:0]  w_lz;
    logic [K_W-1:0]    w_k;
    logic [EXP_W:0]    w_exp_inc;
    logic [EXP_W:0]    w_exp_dec;
    logic [EXP_W-1:0]  w_exp_sub;
    logic [EXP_W-1:0]  w_exp_adj;
    logic [MANT_W-1:0] w_mant_adj;
    logic [MANT_W-1:0] w_mant_shl;
    logic              w_ovf;

    norm_lzc #(.W(MANT_W)) u_lzc (
        .i_vec   (r_mant),
        .o_count (w_lz)
    );

    // Carry-out adjust: right shift by one, exponent +1 computed one bit wider
    assign w_exp_inc  = {1'b0, r_exp} + (EXP_W+1)'(1);
    assign w_ovf      = r_cout && (w_exp_inc >= {1'b0, EXP_MAX});
    assign w_exp_adj  = r_cout ? w_exp_inc[EXP_W-1:0] : r_exp;
    assign w_mant_adj = r_cout ? {1'b1, r_mant[MANT_W-1:1]} : r_mant;

    // Shift amount k = min(leading zeros, step cap, exponent)
    always_comb begin
        w_k = K_W'(w_lz);
        if (K_W'(r_exp) < w_k)    w_k = K_W'(r_exp);
        if (K_W'(STEP_CAP) < w_k) w_k = K_W'(STEP_CAP);
    end

    // Left shift with exponent decrement that saturates at zero
    assign w_mant_shl = r_mant << w_k;
    assign w_exp_dec  = {1'b0, r_exp} - (EXP_W+1)'(w_k);
    assign w_exp_sub  = w_exp_dec[EXP_W] ? '0 : w_exp_dec[EXP_W-1:0];

    // Next-state and datapath update for each phase of the operation
    always_comb begin
        w_state_nxt = r_state;
        w_exp_nxt   = r_exp;
        w_mant_nxt  = r_mant;
        w_cout_nxt  = r_cout;
        w_guard_nxt = r_guard;
        w_flags_nxt = r_flags;
        unique case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    w_exp_nxt   = bus.exp_in;
                    w_mant_nxt  = bus.mant_in;
                    w_cout_nxt  = bus.cout_in;
                    w_guard_nxt = 1'b0;
                    w_flags_nxt = '0;
                    w_state_nxt = ADJ;
                end
            end
            ADJ: begin
                w_guard_nxt = r_cout & r_mant[0];
                if (w_ovf) begin
                    w_flags_nxt[FLG_OVF] = 1'b1;
                    w_exp_nxt            = EXP_MAX;
                    w_mant_nxt           = '0;
                    w_state_nxt          = DONE;
                end else if (w_mant_adj == '0) begin
                    w_flags_nxt[FLG_ZERO] = 1'b1;
                    w_exp_nxt             = '0;
                    w_mant_nxt            = '0;
                    w_state_nxt           = DONE;
                end else begin
                    w_exp_nxt   = w_exp_adj;
                    w_mant_nxt  = w_mant_adj;
                    w_state_nxt = (w_mant_adj[MANT_W-1] || w_exp_adj == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                w_mant_nxt = w_mant_shl;
                w_exp_nxt  = w_exp_sub;
                if (w_mant_shl[MANT_W-1] || w_exp_sub == '0) begin
                    w_state_nxt = DONE;
                    // Exponent floor reached before the mantissa became normal
                    if (!w_mant_shl[MANT_W-1]) w_flags_nxt[FLG_DENORM] = 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State and operand registers with synchronous reset
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_state <= IDLE;
            r_exp   <= '0;
            r_mant  <= '0;
            r_cout  <= 1'b0;
            r_guard <= 1'b0;
            r_flags <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_exp   <= w_exp_nxt;
            r_mant  <= w_mant_nxt;
            r_cout  <= w_cout_nxt;
            r_guard <= w_guard_nxt;
            r_flags <= w_flags_nxt;
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.exp_out   = r_exp;
    assign bus.mant_out  = r_mant;
    assign bus.guard_out = r_guard;
    assign bus.flags_out = r_flags;

endmodule
